// File: rtl/sha_digest_streamer.sv
// sha_digest_streamer: buffers single-cycle digest results and replays each one as a byte stream
module sha_digest_streamer #(
    parameter int DIGEST_BYTES = 48,
    parameter int FIFO_DEPTH   = 4,
    parameter int EMIT_LEN     = 1
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            ivalid,
    input  logic [31:0]                     iid,
    input  logic [60:0]                     ilen,
    input  logic [8*DIGEST_BYTES-1:0]       isha,
    input  logic                            tready,
    output logic                            tvalid,
    output logic                            tlast,
    output logic [31:0]                     tid,
    output logic [7:0]                      tdata,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic [15:0]                     drop_cnt
);
    localparam int T  = DIGEST_BYTES + 8*EMIT_LEN;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(T);

    typedef enum logic {EMPTY, SEND} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             id_mem  [FIFO_DEPTH];
    logic [60:0]             len_mem [FIFO_DEPTH];
    logic [8*DIGEST_BYTES-1:0] sha_mem [FIFO_DEPTH];
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [AW:0]             level_q, level_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic [15:0]             drop_q, drop_d;
    logic [8*T-1:0]          frame;
    logic [7:0]              byte_sel;
    logic                    hs, pop, push;

    generate
        if (EMIT_LEN != 0) begin : g_len
            assign frame = {len_mem[rptr_q], 3'b000, sha_mem[rptr_q]};
        end else begin : g_nolen
            assign frame = sha_mem[rptr_q];
        end
    endgenerate

    // A full FIFO still accepts when the head frame retires in the same cycle
    assign hs   = tvalid & tready;
    assign pop  = hs & tlast;
    assign push = ivalid & ((level_q != (AW+1)'(FIFO_DEPTH)) | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wptr_q]  <= iid;
            len_mem[wptr_q] <= ilen;
            sha_mem[wptr_q] <= isha;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            bcnt_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_q + AW'(push);
            rptr_q  <= rptr_q + AW'(pop);
            level_q <= level_d;
            bcnt_q  <= bcnt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
        bcnt_d  = pop ? '0 : hs ? bcnt_q + BW'(1) : bcnt_q;
        drop_d  = (ivalid & ~push & ~&drop_q) ? drop_q + 16'd1 : drop_q;
    end

    always_comb begin
        state_d = state_q == EMPTY ? (push ? SEND : EMPTY)
                                   : ((pop && level_d == '0) ? EMPTY : SEND);
    end

    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < T; i++)
            if (bcnt_q == BW'(i)) byte_sel = frame[8*(T-1-i) +: 8];
        tvalid   = state_q == SEND;
        tlast    = tvalid & (bcnt_q == BW'(T-1));
        tid      = tvalid ? id_mem[rptr_q] : '0;
        tdata    = tvalid ? byte_sel : '0;
        level    = level_q;
        drop_cnt = drop_q;
    end
endmodule
